poly_fan_split: RTL and testbench

Splits each clipped convex polygon into a fan of triangles and hands them one at a time to rasterizer setup. Sits directly downstream of the four-edge clip controller, which delivers polygons of 0..MAX_VERTS vertices. Also emits each triangle's signed doubled area for winding and backface decisions downstream. Uses valid/ready handshakes on both sides and buffers exactly one polygon.

---
 rtl/poly_fan_split_if.sv | 28 ++
 rtl/poly_fan_split.sv | 130 +++++++++++++
 tb/tb_poly_fan_split.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/poly_fan_split_if.sv
// Handshake bundle between the clip controller, the fan splitter and rasterizer setup.
// The master side supplies polygons and sinks triangles; the slave side is the splitter.
interface poly_fan_split_if #(
  parameter int MAX_VERTS = 8,
  parameter int COORD_W   = 16
);
  logic                           in_valid;
  logic                           in_ready;
  logic [3:0]                     in_nverts;
  logic [MAX_VERTS*COORD_W-1:0]   in_x;
  logic [MAX_VERTS*COORD_W-1:0]   in_y;
  logic                           tri_valid;
  logic                           tri_ready;
  logic [3*COORD_W-1:0]           tri_x;
  logic [3*COORD_W-1:0]           tri_y;
  logic signed [2*COORD_W+1:0]    tri_area2;
  logic                           tri_last;

  modport master (
    output in_valid, in_nverts, in_x, in_y, tri_ready,
    input  in_ready, tri_valid, tri_x, tri_y, tri_area2, tri_last
  );

  modport slave (
    input  in_valid, in_nverts, in_x, in_y, tri_ready,
    output in_ready, tri_valid, tri_x, tri_y, tri_area2, tri_last
  );
endinterface

// File: rtl/poly_fan_split.sv
// Buffers one convex polygon and emits it as a triangle fan around v0,
// together with each triangle's signed doubled area.
module poly_fan_split #(
  parameter int MAX_VERTS = 8,
  parameter int COORD_W   = 16
) (
  input  logic                 clk,
  input  logic                 n_rst,
  poly_fan_split_if.slave      bus,
  output logic [15:0]          drop_cnt
);

  localparam int         IDX_W  = $clog2(MAX_VERTS);
  localparam int         AREA_W = 2*COORD_W + 2;
  localparam logic [3:0] MAX_N  = 4'(MAX_VERTS);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;

  logic [0:0]               state;
  logic [COORD_W-1:0]       vx [MAX_VERTS];
  logic [COORD_W-1:0]       vy [MAX_VERTS];
  logic [3:0]               n_reg;
  logic [3:0]               idx;
  logic [3*COORD_W-1:0]     tri_x_r;
  logic [3*COORD_W-1:0]     tri_y_r;
  logic signed [AREA_W-1:0] area_r;
  logic                     last_r;

  logic [3:0]               n_eff;
  logic [3:0]               nxt;
  logic                     capture;
  logic                     advance;
  logic                     more;
  logic [COORD_W-1:0]       sx0, sx1, sx2, sy0, sy1, sy2;
  logic signed [AREA_W-1:0] sel_area;

  // Differences widened by one bit and products by two, so no corner combination can overflow.
  function automatic logic signed [AREA_W-1:0] area2(
    input logic [COORD_W-1:0] x0, input logic [COORD_W-1:0] y0,
    input logic [COORD_W-1:0] x1, input logic [COORD_W-1:0] y1,
    input logic [COORD_W-1:0] x2, input logic [COORD_W-1:0] y2
  );
    logic signed [COORD_W:0] ax, ay, bx, by;
    ax = $signed({x1[COORD_W-1], x1}) - $signed({x0[COORD_W-1], x0});
    ay = $signed({y1[COORD_W-1], y1}) - $signed({y0[COORD_W-1], y0});
    bx = $signed({x2[COORD_W-1], x2}) - $signed({x0[COORD_W-1], x0});
    by = $signed({y2[COORD_W-1], y2}) - $signed({y0[COORD_W-1], y0});
    return AREA_W'(ax) * AREA_W'(by) - AREA_W'(bx) * AREA_W'(ay);
  endfunction

  assign n_eff   = (bus.in_nverts > MAX_N) ? MAX_N : bus.in_nverts;
  assign capture = bus.in_valid && (state == IDLE);
  assign advance = bus.tri_ready && (state == EMIT);
  assign nxt     = idx + 4'd1;
  assign more    = idx < (n_reg - 4'd1);

  // The first triangle comes straight off the input ports; later ones from the vertex buffer.
  always_comb begin
    sx0 = vx[0];
    sy0 = vy[0];
    sx1 = vx[idx[IDX_W-1:0]];
    sy1 = vy[idx[IDX_W-1:0]];
    sx2 = vx[nxt[IDX_W-1:0]];
    sy2 = vy[nxt[IDX_W-1:0]];
    if (state == IDLE) begin
      sx0 = bus.in_x[0 +: COORD_W];
      sy0 = bus.in_y[0 +: COORD_W];
      sx1 = bus.in_x[COORD_W +: COORD_W];
      sy1 = bus.in_y[COORD_W +: COORD_W];
      sx2 = bus.in_x[2*COORD_W +: COORD_W];
      sy2 = bus.in_y[2*COORD_W +: COORD_W];
    end
    sel_area = area2(sx0, sy0, sx1, sy1, sx2, sy2);
  end

  always_ff @(posedge clk) begin
    if (!n_rst && capture) begin
      for (int i = 0; i < MAX_VERTS; i++) begin
        vx[i] <= bus.in_x[i*COORD_W +: COORD_W];
        vy[i] <= bus.in_y[i*COORD_W +: COORD_W];
      end
    end
  end

  // idx is the buffer index of the presented triangle's c2 corner.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      state    <= IDLE;
      n_reg    <= 4'd0;
      idx      <= 4'd0;
      tri_x_r  <= '0;
      tri_y_r  <= '0;
      area_r   <= '0;
      last_r   <= 1'b0;
      drop_cnt <= 16'd0;
    end else if (capture) begin
      n_reg <= n_eff;
      if (n_eff < 4'd3) begin
        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end else begin
        state   <= EMIT;
        idx     <= 4'd2;
        tri_x_r <= {sx2, sx1, sx0};
        tri_y_r <= {sy2, sy1, sy0};
        area_r  <= sel_area;
        last_r  <= (n_eff == 4'd3);
      end
    end else if (advance) begin
      if (more) begin
        idx     <= nxt;
        tri_x_r <= {sx2, sx1, sx0};
        tri_y_r <= {sy2, sy1, sy0};
        area_r  <= sel_area;
        last_r  <= (nxt == (n_reg - 4'd1));
      end else begin
        state  <= IDLE;
        last_r <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.tri_valid = (state == EMIT);
  assign bus.tri_x     = tri_x_r;
  assign bus.tri_y     = tri_y_r;
  assign bus.tri_area2 = area_r;
  assign bus.tri_last  = last_r;

endmodule

// File: tb/tb_poly_fan_split.sv
// Directed and randomized bench for poly_fan_split; expected fans and areas
// come from a plain-arithmetic model of the fan rules.
module tb_poly_fan_split;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [15:0] drop_cnt;

  int vectors     = 0;
  int miscompares = 0;
  int px [8];
  int py [8];
  int exp_drop    = 0;

  poly_fan_split_if #(.MAX_VERTS(8), .COORD_W(16)) bus ();

  poly_fan_split #(.MAX_VERTS(8), .COORD_W(16)) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .bus      (bus),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic signed [63:0] obs,
                             input logic signed [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic randomPoly();
    for (int i = 0; i < 8; i++) begin
      px[i] = int'($urandom_range(65535)) - 32768;
      py[i] = int'($urandom_range(65535)) - 32768;
    end
  endtask

  task automatic applyStimulus(input int nverts);
    bus.in_valid  = 1'b1;
    bus.in_nverts = 4'(nverts);
    for (int i = 0; i < 8; i++) begin
      bus.in_x[i*16 +: 16] = 16'(px[i]);
      bus.in_y[i*16 +: 16] = 16'(py[i]);
    end
  endtask

  // Triangle k of an n-vertex fan is (v0, v[k+1], v[k+2]).
  task automatic checkTri(input int k, input int n);
    logic [47:0] ex, ey;
    longint      area;
    int          c1, c2;
    c1 = k + 1;
    c2 = k + 2;
    ex = {16'(px[c2]), 16'(px[c1]), 16'(px[0])};
    ey = {16'(py[c2]), 16'(py[c1]), 16'(py[0])};
    area = longint'(px[c1] - px[0]) * longint'(py[c2] - py[0])
         - longint'(px[c2] - px[0]) * longint'(py[c1] - py[0]);
    checkOutput($sformatf("tri_valid[%0d]", k), {63'd0, bus.tri_valid}, 64'sd1);
    checkOutput($sformatf("in_ready_busy[%0d]", k), {63'd0, bus.in_ready}, 64'sd0);
    checkOutput($sformatf("tri_x[%0d]", k), {16'd0, bus.tri_x}, {16'd0, ex});
    checkOutput($sformatf("tri_y[%0d]", k), {16'd0, bus.tri_y}, {16'd0, ey});
    checkOutput($sformatf("tri_area2[%0d]", k), bus.tri_area2, area);
    checkOutput($sformatf("tri_last[%0d]", k), {63'd0, bus.tri_last},
                (k == n - 3) ? 64'sd1 : 64'sd0);
  endtask

  // Called at a negedge with the block idle; returns at a negedge with it idle again.
  task automatic runPoly(input int nverts, input int stall_k, input int stall_len);
    int n;
    n = (nverts > 8) ? 8 : nverts;
    checkOutput("in_ready_idle", {63'd0, bus.in_ready}, 64'sd1);
    applyStimulus(nverts);
    bus.tri_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    if (n < 3) begin
      if (exp_drop < 65535) exp_drop++;
      checkOutput("drop_no_tri", {63'd0, bus.tri_valid}, 64'sd0);
      checkOutput("drop_in_ready", {63'd0, bus.in_ready}, 64'sd1);
      checkOutput("drop_cnt", {48'd0, drop_cnt}, 64'(exp_drop));
      return;
    end
    for (int k = 0; k < n - 2; k++) begin
      checkTri(k, n);
      if (k == stall_k && stall_len > 0) begin
        bus.tri_ready = 1'b0;
        repeat (stall_len) begin
          @(posedge clk);
          @(negedge clk);
          checkTri(k, n);
        end
        bus.tri_ready = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
    end
    checkOutput("tri_valid_done", {63'd0, bus.tri_valid}, 64'sd0);
    checkOutput("in_ready_done", {63'd0, bus.in_ready}, 64'sd1);
  endtask

  initial begin
    n_rst         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_nverts = 4'd0;
    bus.in_x      = '0;
    bus.in_y      = '0;
    bus.tri_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_rst = 1'b0;

    checkOutput("rst_tri_valid", {63'd0, bus.tri_valid}, 64'sd0);
    checkOutput("rst_in_ready", {63'd0, bus.in_ready}, 64'sd1);
    checkOutput("rst_tri_last", {63'd0, bus.tri_last}, 64'sd0);
    checkOutput("rst_tri_x", {16'd0, bus.tri_x}, 64'sd0);
    checkOutput("rst_tri_area2", bus.tri_area2, 64'sd0);
    checkOutput("rst_drop_cnt", {48'd0, drop_cnt}, 64'sd0);

    // Right triangle, area 100
    randomPoly();
    px[0] = 0;  py[0] = 0;
    px[1] = 10; py[1] = 0;
    px[2] = 0;  py[2] = 10;
    runPoly(3, -1, 0);

    // Back-to-back drops of 0, 1 and 2 vertices
    runPoly(0, -1, 0);
    runPoly(1, -1, 0);
    runPoly(2, -1, 0);
    checkOutput("drop_cnt_three", {48'd0, drop_cnt}, 64'sd3);

    // Pentagon without and with a stall on its second triangle
    randomPoly();
    runPoly(5, -1, 0);
    runPoly(5, 1, 4);

    // Count above MAX_VERTS clamps to eight
    randomPoly();
    runPoly(12, 3, 2);

    // Extreme coordinates
    randomPoly();
    px[0] = -32768; py[0] = -32768;
    px[1] = 32767;  py[1] = -32768;
    px[2] = -32768; py[2] = 32767;
    runPoly(3, 0, 1);
    randomPoly();
    px[0] = -32768; py[0] = -32768;
    px[1] = 32767;  py[1] = -32768;
    px[2] = -32768; py[2] = 32767;
    applyStimulus(3);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    checkOutput("area_extreme", bus.tri_area2, 64'sd4294836225);
    @(posedge clk);
    @(negedge clk);

    // Reset while the second of three triangles is stalled
    randomPoly();
    applyStimulus(5);
    bus.tri_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    checkTri(0, 5);
    @(posedge clk);
    @(negedge clk);
    checkTri(1, 5);
    bus.tri_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_rst    = 1'b0;
    exp_drop = 0;
    checkOutput("rst2_tri_valid", {63'd0, bus.tri_valid}, 64'sd0);
    checkOutput("rst2_tri_x", {16'd0, bus.tri_x}, 64'sd0);
    checkOutput("rst2_tri_y", {16'd0, bus.tri_y}, 64'sd0);
    checkOutput("rst2_tri_area2", bus.tri_area2, 64'sd0);
    checkOutput("rst2_tri_last", {63'd0, bus.tri_last}, 64'sd0);
    checkOutput("rst2_in_ready", {63'd0, bus.in_ready}, 64'sd1);
    checkOutput("rst2_drop_cnt", {48'd0, drop_cnt}, 64'sd0);
    randomPoly();
    runPoly(4, -1, 0);

    // Randomized polygons with random stalls
    for (int r = 0; r < 40; r++) begin
      randomPoly();
      runPoly(int'($urandom_range(15)), int'($urandom_range(6)), int'($urandom_range(3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
